// File: rtl/ifetch.sv
// Instruction fetch stage around the pc register: drives the next PC, runs the
// imem req/ack handshake and holds fetched words in an output register with a one-entry skid.
module ifetch #(
  parameter int INST_ADDR_WIDTH = 16,
  parameter int INST_WIDTH      = 16,
  parameter int PC_INCR         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic [INST_ADDR_WIDTH-1:0] pc_in,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [INST_WIDTH-1:0]      imem_rdata,
  input  logic                       branch_valid,
  input  logic [INST_ADDR_WIDTH-1:0] branch_target,
  input  logic                       stall,
  output logic                       inst_valid,
  output logic [INST_WIDTH-1:0]      inst,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  localparam logic [INST_ADDR_WIDTH-1:0] INCR = INST_ADDR_WIDTH'(PC_INCR);

  logic [1:0]                 state, state_nxt;
  logic [INST_WIDTH-1:0]      skid_inst;
  logic [INST_ADDR_WIDTH-1:0] skid_pc;

  logic consume, slot_free, fetch_ack, launch;
  logic load_mem, load_skid, fill_skid;

  assign consume   = inst_valid && !stall;
  assign slot_free = !inst_valid || consume;
  assign fetch_ack = (state == FETCH) && imem_ack;

  // A branch squashes whatever would otherwise move into the output register.
  assign load_mem  = fetch_ack && !branch_valid && slot_free;
  assign fill_skid = fetch_ack && !branch_valid && !slot_free;
  assign load_skid = (state == HOLD) && !branch_valid && slot_free;

  // pc loads every edge, so pc_in must equal pc_out whenever fetch is not advancing.
  // Any ack taken in FETCH (to output or skid) advances; HOLD then launches at pc_out.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pc_in = pc_out;
    if (branch_valid)   pc_in = branch_target;
    else if (fetch_ack) pc_in = pc_out + INCR;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        launch    = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        if (branch_valid) begin
          // An outstanding request cannot be aborted; wait it out in DISCARD.
          if (imem_ack) launch = 1'b1;
          else          state_nxt = DISCARD;
        end else if (imem_ack) begin
          if (slot_free) launch = 1'b1;
          else           state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (branch_valid || slot_free) begin
          launch    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin // DISCARD
        if (imem_ack) begin
          launch    = 1'b1;
          state_nxt = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      skid_inst  <= '0;
      skid_pc    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;

      if (launch) begin
        imem_req  <= 1'b1;
        imem_addr <= pc_in;
      end else if (fill_skid) begin
        imem_req  <= 1'b0;
      end

      if (branch_valid) begin
        inst_valid <= 1'b0;
      end else if (load_mem) begin
        inst_valid <= 1'b1;
        inst       <= imem_rdata;
        inst_pc    <= imem_addr;
      end else if (load_skid) begin
        inst_valid <= 1'b1;
        inst       <= skid_inst;
        inst_pc    <= skid_pc;
      end else if (consume) begin
        inst_valid <= 1'b0;
      end

      // Skid is full exactly while in HOLD; the data regs need no separate valid bit.
      if (fill_skid) begin
        skid_inst <= imem_rdata;
        skid_pc   <= imem_addr;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: models the pc register and a simple instruction memory,
// and compares outputs against hand-computed values.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] pc_in;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        branch_valid = 1'b0;
  logic [15:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;

  // Memory: auto mode acks every cycle returning the address as data.
  logic        auto_mem = 1'b0;
  logic        ack_drv = 1'b0;
  logic [15:0] rdata_drv = '0;

  int vectors = 0;
  int miscompares = 0;

  assign imem_ack   = auto_mem ? 1'b1 : ack_drv;
  assign imem_rdata = auto_mem ? imem_addr : rdata_drv;

  always #5 clk = ~clk;

  // The pc register this stage wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_out <= '0;
    else      pc_out <= pc_in;
  end

  ifetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_out       (pc_out),
    .pc_in        (pc_in),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .stall        (stall),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    auto_mem = 1'b0;
    ack_drv = 1'b0;
    branch_valid = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // ---- reset then zero-wait stream ----
    do_reset();
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_req", 32'(imem_req), 0);
    check("idle_pc_in", 32'(pc_in), 32'h0);
    auto_mem = 1'b1;
    step(); // e1: IDLE -> FETCH
    check("e1_valid", 32'(inst_valid), 0);
    check("e1_req", 32'(imem_req), 1);
    check("e1_addr", 32'(imem_addr), 32'h0);
    step(); // e2
    check("e2_valid", 32'(inst_valid), 1);
    check("e2_inst_pc", 32'(inst_pc), 32'h0);
    check("e2_inst", 32'(inst), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("stream_inst_pc", 32'(inst_pc), 32'(2 * i));
      check("stream_inst", 32'(inst), 32'(2 * i));
    end
    // inst_pc=6, addr=8 outstanding; stall 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_inst_pc", 32'(inst_pc), 32'h6);
      check("stall_req", 32'(imem_req), 0);
      check("stall_pc_hold", 32'(pc_in), 32'(pc_out));
      check("stall_pc_val", 32'(pc_in), 32'hA);
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("unstall_valid", 32'(inst_valid), 1);
      check("unstall_inst_pc", 32'(inst_pc), 32'(8 + 2 * i));
    end

    // ---- branch during a 3-cycle memory wait ----
    do_reset();
    step(); // FETCH, addr 0, no ack
    branch_valid = 1'b1;
    branch_target = 16'h0100;
    #1;
    check("br_pc_in", 32'(pc_in), 32'h0100);
    step();
    branch_valid = 1'b0;
    check("disc_req", 32'(imem_req), 1);
    check("disc_addr_held", 32'(imem_addr), 32'h0);
    step();
    ack_drv = 1'b1;
    rdata_drv = 16'hDEAD;
    #1;
    check("disc_ack_pc_in", 32'(pc_in), 32'h0100);
    step();
    check("disc_dropped", 32'(inst_valid), 0);
    check("br_addr", 32'(imem_addr), 32'h0100);
    rdata_drv = 16'h1234;
    step();
    ack_drv = 1'b0;
    check("br_valid", 32'(inst_valid), 1);
    check("br_inst_pc", 32'(inst_pc), 32'h0100);
    check("br_inst", 32'(inst), 32'h1234);

    // ---- branch + ack + stall in the same cycle ----
    do_reset();
    step();
    ack_drv = 1'b1;
    rdata_drv = 16'hAAAA;
    step();
    check("bas_pre_valid", 32'(inst_valid), 1);
    check("bas_pre_inst", 32'(inst), 32'hAAAA);
    stall = 1'b1;
    branch_valid = 1'b1;
    branch_target = 16'h0040;
    step();
    branch_valid = 1'b0;
    stall = 1'b0;
    ack_drv = 1'b0;
    check("bas_valid", 32'(inst_valid), 0);
    check("bas_addr", 32'(imem_addr), 32'h0040);
    check("bas_req", 32'(imem_req), 1);
    step();
    check("bas_skid_empty", 32'(inst_valid), 0);
    ack_drv = 1'b1;
    rdata_drv = 16'h5555;
    step();
    ack_drv = 1'b0;
    check("bas_inst_pc", 32'(inst_pc), 32'h0040);
    check("bas_inst", 32'(inst), 32'h5555);

    // ---- PC wrap ----
    do_reset();
    step();
    ack_drv = 1'b1;
    branch_valid = 1'b1;
    branch_target = 16'hFFFE;
    step();
    branch_valid = 1'b0;
    check("wrap_addr", 32'(imem_addr), 32'hFFFE);
    rdata_drv = 16'h7777;
    #1;
    check("wrap_pc_in", 32'(pc_in), 32'h0000);
    step();
    check("wrap_inst_pc0", 32'(inst_pc), 32'hFFFE);
    check("wrap_addr0", 32'(imem_addr), 32'h0000);
    rdata_drv = 16'h8888;
    step();
    ack_drv = 1'b0;
    check("wrap_inst_pc1", 32'(inst_pc), 32'h0000);
    check("wrap_inst1", 32'(inst), 32'h8888);

    // ---- asynchronous reset mid-transaction ----
    do_reset();
    step();
    ack_drv = 1'b1;
    rdata_drv = 16'h3C3C;
    step();
    ack_drv = 1'b0;
    check("ar_pre_valid", 32'(inst_valid), 1);
    check("ar_pre_addr", 32'(imem_addr), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    check("ar_req", 32'(imem_req), 0);
    check("ar_valid", 32'(inst_valid), 0);
    check("ar_addr", 32'(imem_addr), 32'h0);
    ack_drv = 1'b1;
    step();
    check("ar_ack_req", 32'(imem_req), 0);
    check("ar_ack_valid", 32'(inst_valid), 0);
    ack_drv = 1'b0;
    rst = 1'b1;
    step();
    check("ar_rel_req", 32'(imem_req), 1);
    check("ar_rel_addr", 32'(imem_addr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage sitting directly around the `pc` register. It consumes the current PC (`pc_out`), issues requests to instruction memory over a req/ack handshake, and presents fetched instructions to decode through an output register backed by a one-entry skid buffer. It generates the next PC (`pc_in`) every cycle. Because `pc` loads unconditionally on every clock edge, this block holds `pc_in` equal to `pc_out` whenever fetch must not advance.

## Interface
- `INST_ADDR_WIDTH`, 16, PC / instruction address width
- `INST_WIDTH`, 16, instruction word width
- `PC_INCR`, 2, sequential PC increment per fetched instruction

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pc_out`  in  INST_ADDR_WIDTH  current PC from `pc`
- `pc_in`  out  INST_ADDR_WIDTH  next PC to `pc` (combinational)
- `imem_req`  out  1  memory request outstanding (registered)
- `imem_addr`  out  INST_ADDR_WIDTH  request address (registered; stable while `imem_req`=1)
- `imem_ack`  in  1  single-cycle completion pulse; `imem_rdata` valid same cycle
- `imem_rdata`  in  INST_WIDTH  fetched instruction
- `branch_valid`  in  1  redirect pulse from execute
- `branch_target`  in  INST_ADDR_WIDTH  redirect address
- `stall`  in  1  decode not ready to accept the output register
- `inst_valid`  out  1  output register holds a valid instruction
- `inst`  out  INST_WIDTH  instruction to decode
- `inst_pc`  out  INST_ADDR_WIDTH  address of `inst`

## Operation
- Reset values: `imem_req`=0, `imem_addr`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, skid empty, state IDLE. `pc_in`=`pc_out` while in IDLE.
- The output register is consumed in any cycle where `inst_valid`=1 and `stall`=0. The slot is free if `inst_valid`=0 or it is consumed this cycle.
- Launch rule: each new request loads `imem_addr`<=`pc_in` and sets `imem_req`=1. This address equals the next `pc_out`.
- `pc_in` is `branch_target` if `branch_valid`. Otherwise it is `pc_out+PC_INCR` (mod 2^W) if an accepted ack occurs in FETCH. In every other case it is `pc_out`.
- States:
  - IDLE: `imem_req`=0. Next edge goes to FETCH with launch.
  - FETCH: request outstanding. On `imem_ack`:
    - If the slot is free, load the output register (`inst`<=`imem_rdata`, `inst_pc`<=`imem_addr`, `inst_valid`<=1), stay in FETCH, and relaunch immediately.
    - Otherwise load the skid register, drop `imem_req`, and go to HOLD.
    - With no ack, stay in FETCH.
  - HOLD: `imem_req`=0 and skid is full. When the slot is free, move skid to the output register and go to FETCH with launch.
  - DISCARD: a wrong-path request is outstanding. `imem_req` and `imem_addr` are held. On `imem_ack`, drop the data and go to FETCH with launch.
- Branch (priority over stall and ack):
  - Clears `inst_valid` and empties skid at the edge. `pc_in`=`branch_target`.
  - In FETCH without ack: go to DISCARD (the request cannot be aborted).
  - In FETCH with ack: drop the data, stay in FETCH, launch at the target.
  - In HOLD or IDLE: go to FETCH, launch at the target.
  - In DISCARD: stay in DISCARD. The new target is taken as the PC.
- `imem_ack` in IDLE or HOLD is ignored.
- Reset asserted mid-transaction: all state clears immediately without a clock, and any outstanding transaction is abandoned. Memory must deassert ack within its own reset.

## Timing
- Ack to `inst_valid`: 1 edge. With a zero-wait memory (ack in the first req cycle), throughput is 1 instruction/cycle.
- Reset release to first `inst_valid`: 2nd rising edge (IDLE, then FETCH with ack).
- Branch at edge n with zero-wait memory: target request during cycle n+1, target instruction valid after edge n+2.
- Stall never loses or duplicates instructions. `imem_req` drops at the edge where skid fills.
- `pc_out+PC_INCR` wraps: 0xFFFE to 0x0000 for W=16, PC_INCR=2.

## Test plan
- Reset then stream. Hold `rst`=0 for 2 cycles, release, `imem_ack` tied 1, `imem_rdata`=`imem_addr` -> `inst_valid` rises at the 2nd edge; `inst_pc`/`inst` = 0,2,4,6… on consecutive cycles.
- Stall/skid. While streaming, `stall`=1 for 3 cycles -> output holds, skid fills, `imem_req`=0, `pc_in`==`pc_out`. After release: consecutive `inst_pc` with no gap or repeat.
- Branch during a 3-cycle memory wait. `branch_target`=0x0100 in cycle 1 of the wait -> that ack's data is dropped; the next `imem_addr`=0x0100; the next valid `inst_pc`=0x0100.
- Branch + ack + stall in the same cycle, target 0x0040 -> `inst_valid`=0 next cycle, skid empty, `imem_addr`=0x0040.
- Wrap. Run fetch up to `pc_out`=0xFFFE, ack -> `pc_in`=0x0000, next `inst_pc`=0x0000.
- Async reset. Drop `rst` mid-cycle with a request outstanding -> `imem_req`, `inst_valid`, `imem_addr` go to 0 before the next edge; an ack during reset has no effect.
